// File: rtl/dec_pkg.sv
// Shared opcode encodings, instruction classes and the decoded-record layout
// for the RV32I/RV64I decode stage.
package dec_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_L     = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_R    = 4'd0,
        CLS_I    = 4'd1,
        CLS_L    = 4'd2,
        CLS_S    = 4'd3,
        CLS_B    = 4'd4,
        CLS_JAL  = 4'd5,
        CLS_JALR = 4'd6,
        CLS_U    = 4'd7,
        CLS_SYS  = 4'd8,
        CLS_ILL  = 4'd9
    } inst_cls_t;

    // imm is held at the widest legal XLEN; the stage narrows it on output
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        inst_cls_t   cls;
        logic        illegal;
    } dec_rec_t;

endpackage

// File: rtl/inst_field_dec.sv
// Combinational RV32I/RV64I field decoder: register/function fields,
// sign-extended immediate, instruction class and illegal flag.
module inst_field_dec
    import dec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0] inst,
    output dec_rec_t    rec
);

    logic [63:0] imm_w;

    always_comb begin
        rec         = '0;
        imm_w       = '0;
        rec.opcode  = inst[6:0];
        rec.funct3  = inst[14:12];
        rec.funct7  = inst[31:25];
        rec.rs1     = inst[19:15];
        rec.rs2     = inst[24:20];
        rec.rd      = inst[11:7];
        rec.cls     = CLS_ILL;
        rec.illegal = 1'b1;
        if (inst[1:0] == 2'b11) begin
            rec.illegal = 1'b0;
            case (inst[6:0])
                OPC_R:     rec.cls = CLS_R;
                OPC_I:     begin rec.cls = CLS_I;    imm_w = {{52{inst[31]}}, inst[31:20]}; end
                OPC_L:     begin rec.cls = CLS_L;    imm_w = {{52{inst[31]}}, inst[31:20]}; end
                OPC_JALR:  begin rec.cls = CLS_JALR; imm_w = {{52{inst[31]}}, inst[31:20]}; end
                // FENCE is ordering-only, so it is grouped with SYSTEM
                OPC_FENCE: begin rec.cls = CLS_SYS;  imm_w = {{52{inst[31]}}, inst[31:20]}; end
                OPC_SYS:   begin rec.cls = CLS_SYS;  imm_w = {{52{inst[31]}}, inst[31:20]}; end
                OPC_S:     begin rec.cls = CLS_S;    imm_w = {{52{inst[31]}}, inst[31:25], inst[11:7]}; end
                OPC_B: begin
                    rec.cls = CLS_B;
                    imm_w   = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
                OPC_JAL: begin
                    rec.cls = CLS_JAL;
                    imm_w   = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                OPC_LUI:   begin rec.cls = CLS_U; imm_w = {{32{inst[31]}}, inst[31:12], 12'b0}; end
                OPC_AUIPC: begin rec.cls = CLS_U; imm_w = {{32{inst[31]}}, inst[31:12], 12'b0}; end
                default: begin
                    rec.cls     = CLS_ILL;
                    rec.illegal = 1'b1;
                end
            endcase
        end
        rec.imm = (XLEN == 32) ? {{32{imm_w[31]}}, imm_w[31:0]} : imm_w;
    end

endmodule

// File: rtl/inst_dec_stage.sv
// Registered decode stage: decodes at accept into a 2-entry head/tail skid
// buffer with valid/ready on both sides, flush, and a consumed-decode counter.
module inst_dec_stage
    import dec_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output inst_cls_t        out_cls,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("inst_dec_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]      state;
    dec_rec_t        dec_w;
    dec_rec_t        head;
    dec_rec_t        tail;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] tail_pc;
    logic            accept;
    logic            consume;

    inst_field_dec #(.XLEN(XLEN)) u_field_dec (
        .inst (in_inst),
        .rec  (dec_w)
    );

    assign in_ready  = rst_n && (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            head      <= '0;
            tail      <= '0;
            head_pc   <= '0;
            tail_pc   <= '0;
            dec_count <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) begin
                    head    <= dec_w;
                    head_pc <= in_pc;
                    state   <= ST_ONE;
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        head    <= dec_w;
                        head_pc <= in_pc;
                    end else if (accept) begin
                        tail    <= dec_w;
                        tail_pc <= in_pc;
                        state   <= ST_TWO;
                    end else if (consume) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: if (consume) begin
                    head    <= tail;
                    head_pc <= tail_pc;
                    state   <= ST_ONE;
                end
                default: state <= ST_EMPTY;
            endcase
            if (consume) dec_count <= dec_count + CNT_W'(1);
        end
    end

    assign out_pc      = head_pc;
    assign out_opcode  = head.opcode;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_imm     = XLEN'(head.imm);
    assign out_cls     = head.cls;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_inst_dec_stage.sv
// Random + directed bench for inst_dec_stage: XLEN=32 and XLEN=64 instances
// share stimulus and are checked against a FIFO-plus-decode reference model.
module tb_inst_dec_stage;
    import dec_pkg::*;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        a_ir, a_ov, a_ill, b_ir, b_ov, b_ill;
    logic [31:0] a_pc, b_pc, a_cnt, b_cnt, a_imm;
    logic [63:0] b_imm;
    logic [6:0]  a_opc, b_opc, a_f7, b_f7;
    logic [2:0]  a_f3, b_f3;
    logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
    logic [3:0]  a_cls, b_cls;

    ent_t        q[$];
    logic [31:0] m_cnt;
    logic        zeroed;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    inst_dec_stage #(.XLEN(32), .PC_W(32), .CNT_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_ov), .out_ready(out_ready),
        .out_pc(a_pc), .out_opcode(a_opc), .out_funct3(a_f3), .out_funct7(a_f7),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
        .out_cls(a_cls), .out_illegal(a_ill), .dec_count(a_cnt));

    inst_dec_stage #(.XLEN(64), .PC_W(32), .CNT_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_ov), .out_ready(out_ready),
        .out_pc(b_pc), .out_opcode(b_opc), .out_funct3(b_f3), .out_funct7(b_f7),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
        .out_cls(b_cls), .out_illegal(b_ill), .dec_count(b_cnt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference decode, straight from the RISC-V immediate formats
    function automatic void model_dec(input logic [31:0] i, output logic [63:0] imm,
                                      output logic [3:0] cls, output logic ill);
        imm = 64'd0;
        cls = CLS_ILL;
        ill = 1'b1;
        if (i[1:0] == 2'b11) begin
            ill = 1'b0;
            case (i[6:0])
                7'h33: cls = CLS_R;
                7'h13: begin cls = CLS_I;    imm = longint'($signed(i[31:20])); end
                7'h03: begin cls = CLS_L;    imm = longint'($signed(i[31:20])); end
                7'h67: begin cls = CLS_JALR; imm = longint'($signed(i[31:20])); end
                7'h0F: begin cls = CLS_SYS;  imm = longint'($signed(i[31:20])); end
                7'h73: begin cls = CLS_SYS;  imm = longint'($signed(i[31:20])); end
                7'h23: begin cls = CLS_S; imm = longint'($signed({i[31:25], i[11:7]})); end
                7'h63: begin cls = CLS_B;
                    imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
                7'h6F: begin cls = CLS_JAL;
                    imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
                7'h37, 7'h17: begin cls = CLS_U; imm = longint'($signed({i[31:12], 12'h000})); end
                default: begin cls = CLS_ILL; ill = 1'b1; end
            endcase
        end
    endfunction

    task automatic check_dut(input string n, input int xl, input logic v, input logic r,
                             input logic [31:0] cnt, input logic [31:0] pc,
                             input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [63:0] imm, input logic [3:0] cls, input logic ill);
        logic [63:0] ei;
        logic [3:0]  ec;
        logic        el;
        ent_t        e;
        chk({n, ".out_valid"}, 64'(v), 64'(q.size() != 0));
        chk({n, ".in_ready"}, 64'(r), 64'(rst_n && q.size() < 2));
        chk({n, ".dec_count"}, 64'(cnt), 64'(m_cnt));
        if (q.size() != 0) begin
            e = q[0];
            model_dec(e.inst, ei, ec, el);
            if (xl == 32) ei = {32'd0, ei[31:0]};
            chk({n, ".pc"}, 64'(pc), 64'(e.pc));
            chk({n, ".opcode"}, 64'(opc), 64'(e.inst[6:0]));
            chk({n, ".funct3"}, 64'(f3), 64'(e.inst[14:12]));
            chk({n, ".funct7"}, 64'(f7), 64'(e.inst[31:25]));
            chk({n, ".rs1"}, 64'(rs1), 64'(e.inst[19:15]));
            chk({n, ".rs2"}, 64'(rs2), 64'(e.inst[24:20]));
            chk({n, ".rd"}, 64'(rd), 64'(e.inst[11:7]));
            chk({n, ".imm"}, imm, ei);
            chk({n, ".cls"}, 64'(cls), 64'(ec));
            chk({n, ".illegal"}, 64'(ill), 64'(el));
        end else if (zeroed) begin
            chk({n, ".rst_pc"}, 64'(pc), 64'd0);
            chk({n, ".rst_opcode"}, 64'(opc), 64'd0);
            chk({n, ".rst_imm"}, imm, 64'd0);
            chk({n, ".rst_cls"}, 64'(cls), 64'd0);
            chk({n, ".rst_illegal"}, 64'(ill), 64'd0);
        end
    endtask

    task automatic check_all();
        check_dut("x32", 32, a_ov, a_ir, a_cnt, a_pc, a_opc, a_f3, a_f7, a_rs1, a_rs2, a_rd,
                  {32'd0, a_imm}, a_cls, a_ill);
        check_dut("x64", 64, b_ov, b_ir, b_cnt, b_pc, b_opc, b_f3, b_f7, b_rs1, b_rs2, b_rd,
                  b_imm, b_cls, b_ill);
    endtask

    // Drive one cycle's inputs, advance the model over the coming edge, then check
    task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rn);
        logic acc, cons;
        ent_t e;
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl; rst_n = rn;
        acc  = rn && iv && (q.size() < 2);
        cons = (q.size() != 0) && ordy;
        if (!rn) begin
            q.delete(); m_cnt = 32'd0; zeroed = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (cons) begin void'(q.pop_front()); m_cnt = m_cnt + 32'd1; end
            if (acc) begin e.inst = inst; e.pc = pc; q.push_back(e); zeroed = 1'b0; end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                  7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 13);
        if (k < 11) return {r[31:7], opcs[k]};
        if (k == 11) return 32'h0000_0000;
        if (k == 12) return 32'h0000_007F;
        return r;
    endfunction

    initial begin
        m_cnt = 32'd0; zeroed = 1'b1;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 32'd0;
        @(negedge clk);
        step(1'b1, 32'h0000_0013, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // addi x1,x0,-1 then consume
        step(1'b1, 32'hFFF0_0093, 32'h100, 1'b1, 1'b0, 1'b1);
        chk("addi_imm32", 64'(a_imm), 64'hFFFF_FFFF);
        chk("addi_rd", 64'(a_rd), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("addi_count", 64'(a_cnt), 64'd1);

        // jal x0,8 then beq x0,x0,-4 back to back
        step(1'b1, 32'h0080_006F, 32'h200, 1'b1, 1'b0, 1'b1);
        chk("jal_imm", 64'(a_imm), 64'h0000_0008);
        step(1'b1, 32'hFE00_0EE3, 32'h204, 1'b1, 1'b0, 1'b1);
        chk("beq_imm", 64'(a_imm), 64'hFFFF_FFFC);
        chk("b2b_ready", 64'(a_ir), 64'd1);

        // lui x1,0x80000 on both widths
        step(1'b1, 32'h8000_00B7, 32'h300, 1'b1, 1'b0, 1'b1);
        chk("lui_imm64", b_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_cls", 64'(b_cls), 64'(CLS_U));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        // stall: A,B stored, C held until release
        step(1'b1, 32'h0010_0113, 32'h400, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0020_0193, 32'h404, 1'b0, 1'b0, 1'b1);
        chk("stall_ready", 64'(a_ir), 64'd0);
        step(1'b1, 32'h0030_0213, 32'h408, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0030_0213, 32'h408, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h0030_0213, 32'h408, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        // flush while full with input offered
        step(1'b1, 32'h0040_0293, 32'h500, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0050_0313, 32'h504, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0060_0393, 32'h508, 1'b1, 1'b1, 1'b1);
        chk("flush_valid", 64'(a_ov), 64'd0);
        chk("flush_ready", 64'(a_ir), 64'd1);

        // illegal encodings, then reset mid-stream
        step(1'b1, 32'h0000_0000, 32'h600, 1'b1, 1'b0, 1'b1);
        chk("ill0_flag", 64'(a_ill), 64'd1);
        step(1'b1, 32'h0000_007F, 32'h604, 1'b0, 1'b0, 1'b1);
        chk("ill7f_cls", 64'(b_cls), 64'(CLS_ILL));
        step(1'b1, 32'h0010_0093, 32'h608, 1'b1, 1'b0, 1'b0);
        chk("rst_count", 64'(a_cnt), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, gen_inst(), $urandom & 32'hFFFF_FFFC,
                 ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 250) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
